// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx byte transmitter between NUM burst
// requesters, with an optional channel header byte and a per-grant burst cap.
module uart_tx_arbiter #(
  parameter int          NUM         = 4,
  parameter int          HEADER      = 1,
  parameter logic [7:0]  HEADER_BASE = 8'hF0,
  parameter int          MAX_BURST   = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NUM-1:0]   req,
  input  logic [NUM-1:0]   valid,
  input  logic [8*NUM-1:0] data,
  output logic [NUM-1:0]   ack,
  output logic [NUM-1:0]   grant,
  output logic [7:0]       uart_data,
  output logic             uart_strobe,
  input  logic             uart_ready
);

  localparam int IW = $clog2(NUM);
  localparam int CW = (MAX_BURST == 0) ? 1 : $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   last_q, last_d;
  logic [CW-1:0]   count_q, count_d;
  logic [NUM-1:0]  grant_d, ack_d;
  logic [7:0]      data_d;
  logic            strobe_d;

  logic            send_ok;
  logic            last_byte;
  logic            release_burst;
  logic [IW-1:0]   pick;
  logic [7:0]      cur_byte;

  // First requesting index after 'last', wrapping modulo NUM.
  function automatic logic [IW-1:0] rr_pick(input logic [NUM-1:0] r,
                                            input logic [IW-1:0]  lst);
    logic [IW-1:0] sel;
    logic          found;
    int            j;
    sel   = lst;
    found = 1'b0;
    for (int i = 1; i <= NUM; i++) begin
      j = (int'(lst) + i) % NUM;
      if (!found && r[IW'(j)]) begin
        sel   = IW'(j);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  // The registered strobe doubles as "strobed last cycle", hiding uart_tx's
  // one-cycle delay before it drops ready.
  assign send_ok   = uart_ready && !uart_strobe;
  assign last_byte = (MAX_BURST != 0) && (32'(count_q) + 32'd1 == 32'(MAX_BURST));
  assign pick      = rr_pick(req, last_q);
  assign cur_byte  = data[{owner_q, 3'b000} +: 8];

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_d        = last_q;
    count_d       = count_q;
    grant_d       = grant;
    ack_d         = '0;
    strobe_d      = 1'b0;
    data_d        = uart_data;
    release_burst = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (|req) begin
          owner_d       = pick;
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          count_d       = '0;
          state_d       = (HEADER != 0) ? HDR : DATA;
        end
      end
      HDR: begin
        // Header goes out even if the owner has already dropped req.
        if (send_ok) begin
          strobe_d = 1'b1;
          data_d   = {HEADER_BASE[7:3], 3'(owner_q)};
          state_d  = DATA;
        end
      end
      DATA: begin
        if (!req[owner_q]) begin
          release_burst = 1'b1;
        end else if (send_ok && valid[owner_q]) begin
          strobe_d        = 1'b1;
          data_d          = cur_byte;
          ack_d[owner_q]  = 1'b1;
          count_d         = count_q + CW'(1);
          release_burst   = last_byte;
        end
      end
      default: state_d = IDLE;
    endcase

    if (release_burst) begin
      grant_d = '0;
      last_d  = owner_q;
      state_d = IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      last_q      <= IW'(NUM - 1);
      count_q     <= '0;
      grant       <= '0;
      ack         <= '0;
      uart_strobe <= 1'b0;
      uart_data   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      count_q     <= count_d;
      grant       <= grant_d;
      ack         <= ack_d;
      uart_strobe <= strobe_d;
      uart_data   <= data_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench: three arbiter configurations driven by behavioural
// producers and compared every cycle against a transaction-level reference.
module tb_uart_tx_arbiter;

  localparam int         NC = 3;
  localparam int         N  = 4;
  localparam logic [7:0] HB = 8'hF0;

  // Instance 0: header, cap 64. Instance 1: header, cap 2. Instance 2: no header, unlimited.
  function automatic int cfg_hd(int k);
    return (k == 2) ? 0 : 1;
  endfunction

  function automatic int cfg_mb(int k);
    return (k == 0) ? 64 : ((k == 1) ? 2 : 0);
  endfunction

  logic             clk;
  logic             rst_n;
  logic [N-1:0]     req_s [NC];
  logic [N-1:0]     val_s [NC];
  logic [8*N-1:0]   dat_s [NC];
  logic             rdy_s [NC];
  logic [N-1:0]     ack_s [NC];
  logic [N-1:0]     gnt_s [NC];
  logic [7:0]       ud_s  [NC];
  logic             stb_s [NC];

  for (genvar k = 0; k < NC; k++) begin : g_dut
    uart_tx_arbiter #(
      .NUM        (N),
      .HEADER     (cfg_hd(k)),
      .HEADER_BASE(HB),
      .MAX_BURST  (cfg_mb(k))
    ) dut (
      .clk        (clk),
      .reset      (rst_n),
      .req        (req_s[k]),
      .valid      (val_s[k]),
      .data       (dat_s[k]),
      .ack        (ack_s[k]),
      .grant      (gnt_s[k]),
      .uart_data  (ud_s[k]),
      .uart_strobe(stb_s[k]),
      .uart_ready (rdy_s[k])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  // Reference model: current owner (-1 = none), header still owed, bytes this burst.
  int         own   [NC];
  int         last  [NC];
  int         cnt   [NC];
  bit         hdr   [NC];
  bit         pstb  [NC];
  logic [7:0] pdata [NC];
  int         rx_n  [NC][N];
  int         tx_n  [NC][N];

  logic [N-1:0] src_on [NC];
  int           vprob;

  logic [7:0]   log_b     [NC][512];
  int           log_len   [NC];
  int           stb_cnt   [NC];
  int           noack_cnt [NC];
  int           b2b       [NC];
  int           ack_cnt   [NC][N];
  int           gr_log    [NC][16];
  int           gr_len    [NC];
  logic         pstb_obs  [NC];
  logic [N-1:0] pgnt_obs  [NC];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Byte n offered by requester i; requester 0 starts 11,22,33.
  function automatic logic [7:0] gen(int i, int n);
    return 8'((n + 1) * 17 + i * 64);
  endfunction

  function automatic logic [7:0] hdr_byte(int g);
    return {HB[7:3], 3'(g)};
  endfunction

  function automatic int rr(int lst, logic [N-1:0] r);
    for (int i = 1; i <= N; i++)
      if (r[(lst + i) % N]) return (lst + i) % N;
    return -1;
  endfunction

  task automatic model_reset(int k);
    own[k]   = -1;
    last[k]  = N - 1;
    cnt[k]   = 0;
    hdr[k]   = 1'b0;
    pstb[k]  = 1'b0;
    pdata[k] = 8'h00;
  endtask

  task automatic clear_log(int k);
    log_len[k]   = 0;
    stb_cnt[k]   = 0;
    noack_cnt[k] = 0;
    b2b[k]       = 0;
    gr_len[k]    = 0;
    for (int i = 0; i < N; i++) ack_cnt[k][i] = 0;
    for (int i = 0; i < 16; i++) gr_log[k][i] = -1;
  endtask

  // One clock: capture applied inputs, predict, compare at the falling edge,
  // then let the producers react to acks.
  task automatic step();
    logic [N-1:0] a_req [NC];
    logic [N-1:0] a_val [NC];
    logic         a_rdy [NC];
    logic         a_rst;
    logic [N-1:0] e_gnt;
    logic [N-1:0] e_ack;
    logic         e_stb;
    logic [7:0]   e_dat;
    bit           send;
    int           g;
    for (int k = 0; k < NC; k++) begin
      a_req[k] = req_s[k];
      a_val[k] = val_s[k];
      a_rdy[k] = rdy_s[k];
    end
    a_rst = rst_n;
    @(negedge clk);
    for (int k = 0; k < NC; k++) begin
      e_gnt = '0;
      e_ack = '0;
      e_stb = 1'b0;
      if (!a_rst) begin
        model_reset(k);
        e_dat = 8'h00;
      end else begin
        e_dat = pdata[k];
        send  = a_rdy[k] && !pstb[k];
        if (own[k] < 0) begin
          g = rr(last[k], a_req[k]);
          if (g >= 0) begin
            own[k]   = g;
            hdr[k]   = (cfg_hd(k) != 0);
            cnt[k]   = 0;
            e_gnt[g] = 1'b1;
          end
        end else begin
          g        = own[k];
          e_gnt[g] = 1'b1;
          if (hdr[k]) begin
            if (send) begin
              e_stb  = 1'b1;
              e_dat  = hdr_byte(g);
              hdr[k] = 1'b0;
            end
          end else if (!a_req[k][g]) begin
            e_gnt   = '0;
            last[k] = g;
            own[k]  = -1;
          end else if (send && a_val[k][g]) begin
            e_stb    = 1'b1;
            e_ack[g] = 1'b1;
            e_dat    = gen(g, rx_n[k][g]);
            rx_n[k][g]++;
            cnt[k]++;
            if (cfg_mb(k) != 0 && cnt[k] == cfg_mb(k)) begin
              e_gnt   = '0;
              last[k] = g;
              own[k]  = -1;
            end
          end
        end
      end
      pstb[k]  = e_stb;
      pdata[k] = e_dat;
      check($sformatf("i%0d_grant", k), 32'(gnt_s[k]), 32'(e_gnt));
      check($sformatf("i%0d_ack", k), 32'(ack_s[k]), 32'(e_ack));
      check($sformatf("i%0d_strobe", k), 32'(stb_s[k]), 32'(e_stb));
      check($sformatf("i%0d_uart_data", k), 32'(ud_s[k]), 32'(e_dat));

      if (stb_s[k]) begin
        if (log_len[k] < 512) log_b[k][log_len[k]] = ud_s[k];
        log_len[k]++;
        stb_cnt[k]++;
        if (ack_s[k] == '0) noack_cnt[k]++;
        if (pstb_obs[k]) b2b[k]++;
      end
      for (int i = 0; i < N; i++) begin
        if (ack_s[k][i]) ack_cnt[k][i]++;
        if (gnt_s[k][i] && pgnt_obs[k] == '0 && gr_len[k] < 16) begin
          gr_log[k][gr_len[k]] = i;
          gr_len[k]++;
        end
      end
      pstb_obs[k] = stb_s[k];
      pgnt_obs[k] = gnt_s[k];
    end

    for (int k = 0; k < NC; k++) begin
      for (int i = 0; i < N; i++) begin
        if (ack_s[k][i]) begin
          val_s[k][i] = 1'b0;
          tx_n[k][i]++;
        end
        if (!val_s[k][i] && src_on[k][i] && int'($urandom_range(0, 99)) < vprob) begin
          val_s[k][i]          = 1'b1;
          dat_s[k][8*i +: 8]   = gen(i, tx_n[k][i]);
        end
      end
    end
  endtask

  logic [7:0] exp2 [12];
  int         n_before;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    vprob    = 100;
    for (int k = 0; k < NC; k++) begin
      req_s[k]    = '0;
      val_s[k]    = '0;
      dat_s[k]    = '0;
      rdy_s[k]    = 1'b0;
      src_on[k]   = '0;
      pstb_obs[k] = 1'b0;
      pgnt_obs[k] = '0;
      model_reset(k);
      clear_log(k);
      for (int i = 0; i < N; i++) begin
        rx_n[k][i] = 0;
        tx_n[k][i] = 0;
      end
    end
    repeat (3) step();
    rst_n = 1'b1;

    // Single burst of three bytes with header.
    clear_log(0);
    src_on[0] = 4'b0001;
    rdy_s[0]  = 1'b1;
    req_s[0]  = 4'b0001;
    for (int t = 0; t < 60 && ack_cnt[0][0] < 3; t++) step();
    req_s[0]  = '0;
    src_on[0] = '0;
    repeat (4) step();
    check("t1_acks", 32'(ack_cnt[0][0]), 32'd3);
    check("t1_len", 32'(log_len[0]), 32'd4);
    check("t1_b0", 32'(log_b[0][0]), 32'hF0);
    check("t1_b1", 32'(log_b[0][1]), 32'h11);
    check("t1_b2", 32'(log_b[0][2]), 32'h22);
    check("t1_b3", 32'(log_b[0][3]), 32'h33);
    check("t1_back_to_back", 32'(b2b[0]), 32'd0);
    check("t1_grant_idle", 32'(gnt_s[0]), 32'd0);

    // Two continuous requesters, cap 2: bursts alternate 1,2,1,2.
    clear_log(1);
    src_on[1] = 4'b0110;
    rdy_s[1]  = 1'b1;
    req_s[1]  = 4'b0110;
    for (int j = 0; j < 2; j++) begin
      exp2[6*j + 0] = hdr_byte(1);
      exp2[6*j + 1] = gen(1, tx_n[1][1] + 2*j);
      exp2[6*j + 2] = gen(1, tx_n[1][1] + 2*j + 1);
      exp2[6*j + 3] = hdr_byte(2);
      exp2[6*j + 4] = gen(2, tx_n[1][2] + 2*j);
      exp2[6*j + 5] = gen(2, tx_n[1][2] + 2*j + 1);
    end
    for (int t = 0; t < 150 && log_len[1] < 12; t++) step();
    req_s[1]  = '0;
    src_on[1] = '0;
    repeat (8) step();
    for (int j = 0; j < 12; j++)
      check($sformatf("t2_byte%0d", j), 32'(log_b[1][j]), 32'(exp2[j]));
    for (int j = 0; j < 4; j++)
      check($sformatf("t2_grant%0d", j), 32'(gr_log[1][j]), 32'((j % 2) + 1));

    // uart_ready low for 50 cycles after grant holds everything back.
    clear_log(2);
    rdy_s[2]  = 1'b0;
    src_on[2] = 4'b0001;
    req_s[2]  = 4'b0001;
    step();
    check("t3_grant", 32'(gnt_s[2]), 32'h1);
    repeat (50) step();
    check("t3_no_strobe", 32'(stb_cnt[2]), 32'd0);
    check("t3_no_ack", 32'(ack_cnt[2][0]), 32'd0);
    rdy_s[2] = 1'b1;
    step();
    check("t3_strobe_on_ready", 32'(stb_s[2]), 32'd1);
    check("t3_ack_on_ready", 32'(ack_s[2]), 32'h1);
    req_s[2]  = '0;
    src_on[2] = '0;
    repeat (4) step();

    // Requester 3 drops req while its byte is pending: byte is abandoned.
    clear_log(0);
    src_on[0] = 4'b1000;
    rdy_s[0]  = 1'b1;
    req_s[0]  = 4'b1000;
    for (int t = 0; t < 60 && ack_cnt[0][3] < 2; t++) step();
    rdy_s[0] = 1'b0;
    repeat (2) step();
    n_before = log_len[0];
    req_s[0] = '0;
    rdy_s[0] = 1'b1;
    step();
    check("t4_grant_released", 32'(gnt_s[0]), 32'd0);
    check("t4_no_ack", 32'(ack_s[0]), 32'd0);
    repeat (5) step();
    check("t4_byte_not_sent", 32'(log_len[0]), 32'(n_before));
    check("t4_ack_total", 32'(ack_cnt[0][3]), 32'd2);
    src_on[0] = '0;

    // Asynchronous reset mid-burst, then requester 0 wins with all requesting.
    clear_log(0);
    src_on[0] = 4'b0100;
    rdy_s[0]  = 1'b1;
    req_s[0]  = 4'b0100;
    for (int t = 0; t < 40 && ack_cnt[0][2] < 1; t++) step();
    check("t5_midburst_grant", 32'(gnt_s[0]), 32'h4);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_grant", 32'(gnt_s[0]), 32'd0);
    check("t5_rst_ack", 32'(ack_s[0]), 32'd0);
    check("t5_rst_strobe", 32'(stb_s[0]), 32'd0);
    check("t5_rst_data", 32'(ud_s[0]), 32'd0);
    req_s[0]  = 4'b1111;
    src_on[0] = 4'b1111;
    repeat (2) step();
    rst_n = 1'b1;
    clear_log(0);
    for (int t = 0; t < 20 && log_len[0] < 1; t++) step();
    check("t5_first_grant", 32'(gr_log[0][0]), 32'd0);
    check("t5_header", 32'(log_b[0][0]), 32'hF0);
    req_s[0]  = '0;
    src_on[0] = '0;
    repeat (6) step();

    // Unlimited burst without header: 300 data bytes under one grant.
    clear_log(2);
    src_on[2] = 4'b0100;
    rdy_s[2]  = 1'b1;
    req_s[2]  = 4'b0100;
    for (int t = 0; t < 1500 && ack_cnt[2][2] < 300; t++) step();
    check("t6_acks", 32'(ack_cnt[2][2]), 32'd300);
    check("t6_strobes", 32'(stb_cnt[2]), 32'd300);
    check("t6_header_free", 32'(noack_cnt[2]), 32'd0);
    check("t6_single_grant", 32'(gr_len[2]), 32'd1);
    check("t6_grant_held", 32'(gnt_s[2]), 32'h4);
    req_s[2]  = '0;
    src_on[2] = '0;
    repeat (4) step();

    // Random traffic on all configurations.
    vprob = 60;
    for (int k = 0; k < NC; k++) src_on[k] = 4'b1111;
    for (int t = 0; t < 3000; t++) begin
      for (int k = 0; k < NC; k++) begin
        for (int i = 0; i < N; i++)
          if ($urandom_range(0, 99) < 6) req_s[k][i] = ~req_s[k][i];
        rdy_s[k] = ($urandom_range(0, 99) < 75);
      end
      step();
    end
    for (int k = 0; k < NC; k++) begin
      req_s[k] = '0;
      rdy_s[k] = 1'b1;
    end
    repeat (10) step();
    for (int k = 0; k < NC; k++)
      check($sformatf("i%0d_end_idle", k), 32'(gnt_s[k]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one uart_tx byte transmitter between NUM independent requesters, e.g. debug, status and SPI-trace streams.
- Each requester holds a request line for the duration of a burst.
- The arbiter grants requesters round-robin and can prefix each burst with a channel header byte.
- It enforces a maximum burst length so that no requester can starve the others.
- It sits between the producers and uart_tx, and drives uart_tx's data/data_strobe/ready handshake directly.

Parameters:
NUM, 4, number of requesters (2..8)
HEADER, 1, 1 = emit header byte (HEADER_BASE | index) at start of each burst; 0 = no header
HEADER_BASE, 8'hF0, upper bits of header byte; low 3 bits replaced by requester index
MAX_BURST, 64, max data bytes per grant; 0 = unlimited

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset (reset=0 resets)
req  input  NUM  per-requester burst request, level
valid  input  NUM  per-requester byte available
data  input  8*NUM  per-requester byte; requester i uses bits [8i+7:8i]
ack  output  NUM  one-cycle pulse: requester's current byte accepted
grant  output  NUM  one-hot; current owner of the UART
uart_data  output  8  byte to uart_tx
uart_strobe  output  1  one-cycle load strobe to uart_tx
uart_ready  input  1  uart_tx idle/ready

Behaviour:
- Reset (async assert, sync release):
  - grant=0, ack=0, uart_strobe=0, uart_data=0.
  - State=IDLE, burst count=0.
  - last=NUM-1, so requester 0 has first priority.
- Send rule: uart_strobe may assert only when uart_ready=1 and uart_strobe was 0 in the previous cycle. This covers uart_tx's one-cycle ready-deassert latency.
- uart_strobe and ack are registered single-cycle pulses. uart_data is registered together with uart_strobe and holds its value until the next strobe.
- Byte count width is clog2(MAX_BURST+1).
- IDLE:
  - If req!=0, search indices last+1, last+2, ... (mod NUM) and take the first set bit g.
  - Next cycle: grant=onehot(g), count=0.
  - Go to HDR if HEADER=1, else to DATA.
- HDR:
  - On the first send-rule cycle: uart_data=HEADER_BASE[7:3]<<3 | g, uart_strobe=1.
  - Go to DATA. No ack is generated for the header.
- DATA, evaluated each cycle in this priority order:
  1. If req[g]=0: release.
  2. Else if the send rule holds and valid[g]=1: uart_data=data[g], uart_strobe=1, ack[g]=1, count=count+1.
     - If MAX_BURST!=0 and count+1==MAX_BURST: release in the same cycle as this strobe.
  3. Else: wait.
- Release:
  - grant=0 on the next cycle, last=g, return to IDLE.
  - The released requester can be re-granted only after the other pending requesters, per round-robin.
  - If it is the only requester, it is re-granted in the next IDLE pass; a header is sent again when HEADER=1.
- IDLE always takes one cycle, so there is a minimum one-cycle gap between grants.
- req[g] dropping while valid[g]=1: that byte is not sent and no ack is given.
- req[g] dropping in the same cycle as a strobe/ack: the byte is sent. Release occurs on the following evaluation.
- Requesters must hold data/valid stable until ack. valid without req is ignored.
- The header is sent even if the requester drops req after grant. A burst may therefore consist of a header only.
- Only the granted index can ever receive ack; ack and grant for other indices stay 0.
- Reset mid-burst: outputs clear immediately. A byte already strobed into uart_tx is not recalled; uart_tx owns it.

Test Plan:
- NUM=4, HEADER=1. req[0]=1 with bytes 11,22,33 presented, uart_ready=1, then req[0]=0 -> uart sequence F0,11,22,33. ack[0] pulses exactly 3 times. No two strobes in consecutive cycles. grant returns to 0.
- req[1] and req[2] held continuously, MAX_BURST=2, unlimited data -> header/byte order F1,a,b,F2,c,d,F1,... Grants alternate 1,2,1,2.
- uart_ready held 0 for 50 cycles after grant, with valid[0]=1 -> no strobe and no ack. Strobe fires on the first cycle uart_ready rises.
- During DATA, req[3]=0 while valid[3]=1 with byte 5A -> 5A never strobed, ack[3] stays 0. grant goes 0 on the next cycle.
- reset=0 pulse mid-burst, async to clk -> grant/ack/uart_strobe are 0 before the next clock edge. After release with req=4'b1111, requester 0 is granted first, header F0.
- HEADER=0, MAX_BURST=0. req[2] streams 300 bytes -> 300 strobes, none of them header bytes, with a single grant throughout.
